lsu_mem_req: RTL and testbench
==============================

Name: lsu_mem_req

Overview:
- Load/store requester: the initiator end of the core-to-memory data path.
- Accepts one load or store from the EX/MEM stage over a valid/ready handshake.
- Drives a doubleword-aligned request with byte mask and lane-shifted write data to the memory responder, then waits for its response.
- Returns lane-extracted, sign/zero-extended load data, or a store completion, with error flags for misalignment and response timeout.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles spent in WAIT before aborting with a timeout error. Must be at least 2.
- CNT_W, 9: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  core request valid
- in_ready  out  1  requester can accept a new operation
- in_wen  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword
- in_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- in_addr  in  64  byte address
- in_wdata  in  64  store data, right-aligned
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_wen  out  1  write enable
- mem_req_addr  out  64  {addr[63:3], 3'b000}
- mem_req_wdata  out  64  store data shifted left by addr[2:0]*8
- mem_req_wmask  out  8  byte lanes written; 0 for loads
- mem_resp_valid  in  1  response valid; also the store acknowledge
- mem_resp_rdata  in  64  full aligned doubleword
- out_valid  out  1  operation complete
- out_ready  in  1  core consumes the result
- out_rdata  out  64  extended load data; 0 for stores and errors
- out_err_misalign  out  1  address not aligned to size
- out_err_timeout  out  1  no response within TIMEOUT_CYCLES

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset state: state=IDLE, timeout counter=0, all latched fields=0.
  - Outputs in reset: in_ready=1; mem_req_valid=0, mem_req_wen=0, mem_req_wmask=0; out_valid=0; out_rdata=0; both err flags=0.
  - rst has priority in every state. An in-flight request is dropped without completion. A response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE. All outputs are registered or decoded from state and latched fields only; no input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid, latch wen, size, unsigned, addr and wdata.
  - Alignment check:
    - half needs addr[0]=0.
    - word needs addr[1:0]=0.
    - dword needs addr[2:0]=0.
    - byte always passes.
  - Misaligned: go to DONE with out_err_misalign=1. No memory request is issued.
  - Aligned: go to REQ.
- REQ:
  - mem_req_valid=1, with addr, wen, wmask and wdata held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready: go to WAIT and clear the counter.
- WAIT:
  - mem_req_valid=0. The counter increments each cycle.
  - mem_resp_valid is sampled only in WAIT; it is ignored in all other states.
  - On mem_resp_valid: go to DONE.
    - Load: out_rdata = extend((mem_resp_rdata >> addr[2:0]*8) truncated to size).
    - Store: out_rdata = 0.
  - If counter==TIMEOUT_CYCLES-1 with no response: go to DONE with out_err_timeout=1.
  - A response on the timeout cycle wins; no error is flagged.
- DONE:
  - out_valid=1; result and err flags held stable until out_ready. Then go to IDLE and clear the err flags.
  - in_ready=0, so no overlap: at most one operation is outstanding.
- Write-data and mask rules, with off=addr[2:0]:
  - wmask = (8'h01, 8'h03, 8'h0F, 8'hFF for size 0..3) << off, for stores only.
  - mem_req_wdata = in_wdata << off*8. Bits outside the mask are don't-care.
- Extension: byte extends from bit 7, half from bit 15, word from bit 31; dword passes through.
- Minimum latency: accept at cycle 0 → REQ at 1 → WAIT at 2 → DONE at 3, with ready and response asserted immediately. Misaligned operations complete in DONE at cycle 1.

Test Plan:
- Signed byte load at 0x80000005, resp_rdata=0x0000_8000_0000_0000: req_addr=0x80000000, wmask=0, out_rdata=0xFFFF_FFFF_FFFF_FF80. Unsigned load of the same gives 0x80.
- Word store at 0x80000004, wdata=0xDEADBEEF: req_addr=0x80000000, wmask=0xF0, wdata[63:32]=0xDEADBEEF, wen=1; out_valid after resp, out_rdata=0.
- Half load at 0x80000003: no mem_req_valid; out_valid the cycle after accept, out_err_misalign=1. Dword at 0x80000008 is accepted normally.
- mem_req_ready held low for 5 cycles: mem_req_valid and fields stable for all 5; response 3 cycles later completes. With out_ready low for 4 cycles, out_valid and data stay held and in_ready=0.
- With TIMEOUT_CYCLES=4 and no response: out_err_timeout=1 after 4 WAIT cycles. A response exactly on the 4th cycle completes without error. A late response is then ignored in DONE and IDLE.
- rst asserted in WAIT, then a stale mem_resp_valid: next cycle is IDLE with in_ready=1 and out_valid=0; a fresh load afterwards completes correctly.

Source files
------------

// File: rtl/lsu_mem_req_if.sv
// Core-side and memory-side handshake bundle of the load/store requester.
// The requester connects through the slave modport; the environment that
// drives the core request, memory responder and result consumer uses master.
interface lsu_mem_req_if;
    // core request
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    // memory request
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    // memory response
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    // result
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_err_misalign;
    logic        out_err_timeout;

    modport master (
        output in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
        input  in_ready,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata,
        input  out_valid, out_rdata, out_err_misalign, out_err_timeout,
        output out_ready
    );

    modport slave (
        input  in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
        output in_ready,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata,
        output out_valid, out_rdata, out_err_misalign, out_err_timeout,
        input  out_ready
    );
endinterface

// File: rtl/lsu_mem_req.sv
// Load/store requester: accepts one core operation, issues a doubleword-aligned
// memory request, waits for the response (with timeout) and returns extended
// load data or a store completion. One operation outstanding at a time.
module lsu_mem_req #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic         clk,
    input  logic         rst,
    lsu_mem_req_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            2'd3:    return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    // Pick the addressed lane out of the doubleword and extend it to 64 bits.
    function automatic logic [63:0] load_ext(input logic [63:0] rd, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        sh = rd >> {off, 3'b000};
        case (size)
            2'd0:    return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    // State and latched operation fields; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_mis_q <= err_mis_d;
            err_to_q  <= err_to_d;
        end
    end

    // Next-state: accept/align check, request handshake, response/timeout, result hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_mis_d = err_mis_q;
        err_to_d  = err_to_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                wen_d   = bus.in_wen;
                size_d  = bus.in_size;
                uns_d   = bus.in_unsigned;
                addr_d  = bus.in_addr;
                wdata_d = bus.in_wdata;
                if (misaligned(bus.in_size, bus.in_addr[2:0])) begin
                    state_d   = DONE;
                    err_mis_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (bus.mem_req_ready) begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a response on the final cycle still wins over the timeout
                if (bus.mem_resp_valid) begin
                    state_d = DONE;
                    rdata_d = wen_q ? 64'd0 : load_ext(bus.mem_resp_rdata, addr_q[2:0], size_q, uns_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    err_to_d = 1'b1;
                    rdata_d  = '0;
                end
            end
            DONE: if (bus.out_ready) begin
                state_d   = IDLE;
                err_mis_d = 1'b0;
                err_to_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [7:0] size_mask;
    always_comb begin
        case (size_q)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Outputs decode only from state and latched fields.
    assign bus.in_ready         = (state_q == IDLE);
    assign bus.mem_req_valid    = (state_q == REQ);
    assign bus.mem_req_wen      = (state_q == REQ) && wen_q;
    assign bus.mem_req_addr     = {addr_q[63:3], 3'b000};
    assign bus.mem_req_wdata    = wdata_q << {addr_q[2:0], 3'b000};
    assign bus.mem_req_wmask    = ((state_q == REQ) && wen_q) ? (size_mask << addr_q[2:0]) : 8'h00;
    assign bus.out_valid        = (state_q == DONE);
    assign bus.out_rdata        = rdata_q;
    assign bus.out_err_misalign = err_mis_q;
    assign bus.out_err_timeout  = err_to_q;
endmodule

// File: tb/tb_lsu_mem_req.sv
// Self-checking bench for lsu_mem_req: directed scenarios plus randomized
// operations compared against a byte-level reference model.
module tb_lsu_mem_req;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchecks = 0;
    int   nfail = 0;
    logic [63:0] last_rdata;
    logic [7:0]  last_wmask;
    logic [63:0] last_wdata;

    lsu_mem_req_if bus();

    lsu_mem_req #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_misalign(input logic [1:0] size, input logic [63:0] addr);
        int nbytes;
        nbytes = 1 << size;
        return (addr % nbytes) != 0;
    endfunction

    function automatic logic [7:0] model_wmask(input logic [1:0] size, input logic [2:0] off);
        int m;
        m = ((1 << (1 << size)) - 1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
        int          nbits;
        logic [127:0] mask, val;
        nbits = 8 * (1 << size);
        mask  = (128'd1 << nbits) - 128'd1;
        val   = ({64'd0, rd} >> (8 * off)) & mask;
        if (!uns && val[nbits-1]) val = val | ~mask;
        return val[63:0];
    endfunction

    // Runs one operation end to end with the given stall pattern.
    task automatic run_op(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rresp,
                          input int req_wait, input int resp_wait, input int out_wait);
        logic        mis;
        logic [2:0]  off;
        logic [7:0]  emask;
        logic [63:0] erd, bexp;
        off   = addr[2:0];
        mis   = model_misalign(size, addr);
        emask = (wen && !mis) ? model_wmask(size, off) : 8'h00;
        erd   = (wen || mis) ? 64'd0 : model_load(rresp, off, size, uns);
        for (int b = 0; b < 8; b++) bexp[8*b +: 8] = {8{emask[b]}};

        nchecks++;
        if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL op_in_ready got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b1; bus.in_wen = wen; bus.in_size = size; bus.in_unsigned = uns;
        bus.in_addr = addr; bus.in_wdata = wdata;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_addr = {$urandom, $urandom}; bus.in_wdata = {$urandom, $urandom};
        bus.in_wen = ~wen; bus.in_size = size + 2'd1;

        if (mis) begin
            nchecks++;
            if (bus.mem_req_valid !== 1'b0) begin nfail++; $display("FAIL mis_no_req got=%b exp=0", bus.mem_req_valid); end
        end else begin
            for (int i = 0; i <= req_wait; i++) begin
                nchecks++;
                if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== {addr[63:3], 3'b000} ||
                    bus.mem_req_wen !== wen || bus.mem_req_wmask !== emask ||
                    ((bus.mem_req_wdata & bexp) !== ((wdata << (8 * off)) & bexp))) begin
                    nfail++;
                    $display("FAIL req_fields v=%b a=%h wen=%b m=%h wd=%h exp a=%h wen=%b m=%h wd=%h",
                             bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask,
                             bus.mem_req_wdata & bexp, {addr[63:3], 3'b000}, wen, emask,
                             (wdata << (8 * off)) & bexp);
                end
                last_wmask = bus.mem_req_wmask;
                last_wdata = bus.mem_req_wdata;
                if (i == req_wait) bus.mem_req_ready = 1'b1;
                @(negedge clk);
            end
            bus.mem_req_ready = 1'b0;
            for (int i = 0; i <= resp_wait; i++) begin
                nchecks++;
                if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
                    nfail++; $display("FAIL wait_state req_v=%b out_v=%b exp 0 0", bus.mem_req_valid, bus.out_valid);
                end
                if (i == resp_wait) begin bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rresp; end
                @(negedge clk);
            end
            bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = {$urandom, $urandom};
        end

        for (int i = 0; i <= out_wait; i++) begin
            nchecks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_rdata !== erd ||
                bus.out_err_misalign !== mis || bus.out_err_timeout !== 1'b0) begin
                nfail++;
                $display("FAIL done_hold v=%b rdy=%b rd=%h mis=%b to=%b exp v=1 rdy=0 rd=%h mis=%b to=0",
                         bus.out_valid, bus.in_ready, bus.out_rdata, bus.out_err_misalign,
                         bus.out_err_timeout, erd, mis);
            end
            last_rdata = bus.out_rdata;
            if (i == out_wait) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        nchecks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_err_misalign !== 1'b0 ||
            bus.out_err_timeout !== 1'b0) begin
            nfail++; $display("FAIL back_idle v=%b rdy=%b mis=%b to=%b exp 0 1 0 0", bus.out_valid,
                              bus.in_ready, bus.out_err_misalign, bus.out_err_timeout);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.mem_req_wen !== 1'b0 ||
            bus.mem_req_wmask !== 8'h00 || bus.out_valid !== 1'b0 || bus.out_rdata !== 64'd0 ||
            bus.out_err_misalign !== 1'b0 || bus.out_err_timeout !== 1'b0) begin
            nfail++; $display("FAIL reset_outputs rdy=%b rv=%b wen=%b m=%h ov=%b rd=%h mis=%b to=%b",
                              bus.in_ready, bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_wmask,
                              bus.out_valid, bus.out_rdata, bus.out_err_misalign, bus.out_err_timeout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_load();
        run_op(1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, 0);
        nchecks++;
        if (last_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin nfail++; $display("FAIL sbyte_load got=%h exp=ffffffffffffff80", last_rdata); end
        nchecks++;
        if (last_wmask !== 8'h00) begin nfail++; $display("FAIL load_wmask got=%h exp=00", last_wmask); end
        run_op(1'b0, 2'd0, 1'b1, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, 0);
        nchecks++;
        if (last_rdata !== 64'h80) begin nfail++; $display("FAIL ubyte_load got=%h exp=80", last_rdata); end
    endtask

    task automatic test_word_store();
        run_op(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 0, 1, 0);
        nchecks++;
        if (last_wmask !== 8'hF0 || last_wdata[63:32] !== 32'hDEAD_BEEF) begin
            nfail++; $display("FAIL word_store m=%h wd_hi=%h exp m=f0 wd_hi=deadbeef", last_wmask, last_wdata[63:32]);
        end
        nchecks++;
        if (last_rdata !== 64'd0) begin nfail++; $display("FAIL store_rdata got=%h exp=0", last_rdata); end
    endtask

    task automatic test_misalign();
        run_op(1'b0, 2'd1, 1'b0, 64'h8000_0003, 64'd0, 64'd0, 0, 0, 0);
        run_op(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'hFFFF, 64'd0, 0, 0, 2);
        run_op(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        nchecks++;
        if (last_rdata !== 64'h0123_4567_89AB_CDEF) begin nfail++; $display("FAIL dword_load got=%h exp=0123456789abcdef", last_rdata); end
    endtask

    task automatic test_stalls();
        run_op(1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_9876_0000, 5, 3, 4);
        nchecks++;
        if (last_rdata !== 64'hFFFF_FFFF_FFFF_9876) begin nfail++; $display("FAIL stall_half got=%h exp=ffffffffffff9876", last_rdata); end
    endtask

    task automatic test_timeout();
        bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_size = 2'd3; bus.in_unsigned = 1'b0;
        bus.in_addr = 64'h1000;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchecks++;
            if (bus.out_valid !== 1'b0) begin nfail++; $display("FAIL timeout_early cyc=%0d out_v=%b exp=0", i, bus.out_valid); end
        end
        @(negedge clk);
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.out_err_timeout !== 1'b1 || bus.out_rdata !== 64'd0 ||
            bus.out_err_misalign !== 1'b0) begin
            nfail++; $display("FAIL timeout_flag v=%b to=%b rd=%h mis=%b exp 1 1 0 0", bus.out_valid,
                              bus.out_err_timeout, bus.out_rdata, bus.out_err_misalign);
        end
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        nchecks++;
        if (bus.out_valid !== 1'b1 || bus.out_err_timeout !== 1'b1 || bus.out_rdata !== 64'd0) begin
            nfail++; $display("FAIL late_resp_done v=%b to=%b rd=%h exp 1 1 0", bus.out_valid, bus.out_err_timeout, bus.out_rdata);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
            bus.out_err_timeout !== 1'b0) begin
            nfail++; $display("FAIL late_resp_idle rdy=%b v=%b rv=%b to=%b exp 1 0 0 0", bus.in_ready,
                              bus.out_valid, bus.mem_req_valid, bus.out_err_timeout);
        end
        bus.mem_resp_valid = 1'b0;
        // response on the last permitted WAIT cycle completes cleanly
        run_op(1'b0, 2'd2, 1'b1, 64'h2004, 64'd0, 64'hC000_0001_0000_0000, 0, 3, 0);
    endtask

    task automatic test_reset_in_wait();
        bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_size = 2'd2; bus.in_unsigned = 1'b0;
        bus.in_addr = 64'h3000;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 64'h5555_5555_5555_5555;
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            nfail++; $display("FAIL rst_wait rdy=%b v=%b rv=%b exp 1 0 0", bus.in_ready, bus.out_valid, bus.mem_req_valid);
        end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        nchecks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            nfail++; $display("FAIL stale_resp rdy=%b v=%b exp 1 0", bus.in_ready, bus.out_valid);
        end
        run_op(1'b0, 2'd0, 1'b0, 64'h3001, 64'd0, 64'h0000_0000_0000_7F00, 0, 0, 0);
        nchecks++;
        if (last_rdata !== 64'h7F) begin nfail++; $display("FAIL after_rst_load got=%h exp=7f", last_rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  sz;
            logic [63:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_op(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_size = 2'd0; bus.in_unsigned = 1'b0;
        bus.in_addr = '0; bus.in_wdata = '0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0; bus.out_ready = 1'b0;
        last_rdata = '0; last_wmask = '0; last_wdata = '0;
        @(negedge clk);
        test_reset();
        test_byte_load();
        test_word_store();
        test_misalign();
        test_stalls();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
